pwm_modulador: RTL and testbench
================================

# pwm_modulador

PWM modulator for the audio output path. It generates the free-running 5-bit `contador` sawtooth and accepts duty-cycle samples through a valid/ready handshake. Each sample is double-buffered so duty changes take effect only at a period boundary, and the block drives the glitch-free `pwm_out` pin toward the audio filter. It is the consumer of the duty-reference stream: it owns the counter and turns the duty value into the pin waveform.

## Interface
Parameters:
- `PRESC`, default 4: clk cycles per `contador` step; legal range ≥1.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_central`  in  1  reset, asynchronous, active-high.
- `ref_data`  in  5  duty sample, unsigned 0..31 counts.
- `ref_valid`  in  1  `ref_data` is valid.
- `ref_ready`  out  1  pending buffer empty; a sample is accepted on an edge where `ref_valid & ref_ready`.
- `contador`  out  5  sawtooth counter, registered.
- `pwm_out`  out  1  modulated output.
- `period_end`  out  1  one-clk pulse marking the start of a new period.
- `underrun`  out  1  sticky flag; exists only with `PWM_UNDERRUN_EN`.

## Operation
Prescaler:
- Counts 0..PRESC-1 and wraps.
- `tick` is asserted when the prescaler equals PRESC-1.
- With PRESC=1, `tick` is asserted every cycle.

Counter:
- On `tick`, `contador` increments.
- It wraps from 31 to 0 with no skip.

Buffers:
- `duty_pend` plus a `pend_full` flag hold the next duty value.
- `duty_act` holds the duty value currently in use.
- `ref_ready = ~pend_full` (combinational from the register).
- Accept: `duty_pend <= ref_data`, `pend_full <= 1`.

Boundary (`tick` with `contador==31`):
- If `pend_full`: `duty_act <= duty_pend`, `pend_full <= 0`.
- Otherwise: `duty_act` holds its value and an underrun event occurs.
- A sample accepted on the boundary edge itself (only possible when `pend_full=0`) goes into `duty_pend`, not straight into `duty_act`. That boundary still counts as an underrun.

Output:
- `pwm_out = (contador < duty_act)`. Both operands are registered, so the output is glitch-free.
- Duty 0 gives a constant low output.
- Duty 31 gives high for 31 of every 32 counts.
- A full 100% duty is not reachable, by design.

`period_end`:
- Registered.
- High for exactly one clk cycle, namely the first cycle in which `contador==0` after a wrap.

Reset (asynchronous, active-high `reset_central`):
- Clears the prescaler, `contador`, `duty_act`, `duty_pend`, `pend_full`, `pwm_out`, `period_end` and `underrun` to 0, so `ref_ready=1`.
- Asserting reset mid-period or mid-handshake drops any pending sample.
- The first period after reset is output at duty 0.

## Timing
- Period = 32·PRESC clk cycles.
- `ref_ready` falls on the clk edge that accepts a sample and rises on the next boundary edge.
- Back-to-back samples: the first sample fills `duty_pend`. The second sample stalls with `ref_ready=0` until the boundary moves the first into `duty_act`; it is then accepted one cycle later at the earliest.
- Sample-to-pin latency: from acceptance to the next boundary. Worst case is 32·PRESC cycles.
- A new `duty_act` affects `pwm_out` from the first `contador==0` cycle, the same cycle in which `period_end=1`.

## Configuration
`PWM_UNDERRUN_EN`:
- Defined: the `underrun` port and logic are present. The flag is set on the edge of any boundary that finds `pend_full=0`. It stays set until `reset_central`; new samples do not clear it.
- Undefined: the port and logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert `reset_central` mid-period with `contador=17` and `pwm_out=1` → immediately `contador=0`, `pwm_out=0`, `period_end=0`, `ref_ready=1` (`underrun=0`); the counter restarts from 0 after release.
- Duty load, PRESC=1: accept `ref_data=6` during period 0 → from the next boundary `pwm_out` is high for exactly 6 clk (`contador` 0..5) and low for 26; `period_end` pulses every 32 clk.
- Extremes, PRESC=1: duty 0 → `pwm_out` is never high in a full period; duty 31 → high for 31 clk, low only at `contador=31`.
- Backpressure, PRESC=1: present 10 then 20 with `ref_valid` held → 10 is accepted, `ref_ready=0` until the boundary, 20 is accepted the cycle after; the next period uses duty 10 and the one after uses duty 20.
- Underrun (macro on): load 12, then supply nothing for one period → the duty stays 12, `underrun` rises on that boundary edge and stays 1 after a later sample of 5; with the macro off the waveform is identical and there is no port.
- Prescaler, PRESC=4, duty 8: `contador` steps every 4 clk, period = 128 clk, `pwm_out` is high for 32 clk per period.

Source files
------------

// File: rtl/pwm_modulador_if.sv
// Duty-sample valid/ready handshake between the reference producer (master)
// and pwm_modulador (slave).
interface pwm_modulador_if;
    logic [4:0] ref_data;
    logic       ref_valid;
    logic       ref_ready;

    modport master (output ref_data, output ref_valid, input ref_ready);
    modport slave  (input ref_data, input ref_valid, output ref_ready);
endinterface

// File: rtl/pwm_modulador.sv
// Audio PWM modulator: prescaled 5-bit sawtooth, double-buffered duty sample,
// glitch-free pwm_out. Optional sticky underrun flag enabled by PWM_UNDERRUN_EN.
module pwm_modulador #(
    parameter int PRESC = 4
) (
    input  logic             clk,
    input  logic             reset_central,
    pwm_modulador_if.slave   ref_bus,
    output logic [4:0]       contador,
    output logic             pwm_out,
    output logic             period_end
`ifdef PWM_UNDERRUN_EN
    ,
    output logic             underrun
`endif
);
    localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0] presc_r, presc_next_s;
    logic [4:0]    contador_r, contador_next_s;
    logic [4:0]    duty_act_r, duty_act_next_s;
    logic [4:0]    duty_pend_r, duty_pend_next_s;
    logic          pend_full_r, pend_full_next_s;
    logic          pwm_out_r, period_end_r;
    logic          tick_s, boundary_s, accept_s;
`ifdef PWM_UNDERRUN_EN
    logic          underrun_r, underrun_next_s;
`endif

    // Next-state logic for prescaler, counter and the duty double buffer.
    always_comb begin
        tick_s           = (presc_r == PRESC_LAST);
        boundary_s       = tick_s && (contador_r == 5'd31);
        accept_s         = ref_bus.ref_valid && !pend_full_r;
        presc_next_s     = presc_r;
        contador_next_s  = contador_r;
        duty_act_next_s  = duty_act_r;
        duty_pend_next_s = duty_pend_r;
        pend_full_next_s = pend_full_r;

        if (tick_s) begin
            presc_next_s    = '0;
            contador_next_s = contador_r + 5'd1;
        end else begin
            presc_next_s    = presc_r + PW'(1);
        end

        // Promotion and acceptance are exclusive: acceptance needs an empty pending slot.
        if (boundary_s && pend_full_r) begin
            duty_act_next_s  = duty_pend_r;
            pend_full_next_s = 1'b0;
        end else if (accept_s) begin
            duty_pend_next_s = ref_bus.ref_data;
            pend_full_next_s = 1'b1;
        end else begin
            duty_pend_next_s = duty_pend_r;
            pend_full_next_s = pend_full_r;
        end
    end

`ifdef PWM_UNDERRUN_EN
    // Sticky underrun: any boundary that finds no pending sample.
    always_comb begin
        underrun_next_s = underrun_r | (boundary_s & ~pend_full_r);
    end
`endif

    // State registers; pwm_out is computed from next-state values so it lines up with contador.
    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            presc_r      <= '0;
            contador_r   <= 5'd0;
            duty_act_r   <= 5'd0;
            duty_pend_r  <= 5'd0;
            pend_full_r  <= 1'b0;
            pwm_out_r    <= 1'b0;
            period_end_r <= 1'b0;
        end else begin
            presc_r      <= presc_next_s;
            contador_r   <= contador_next_s;
            duty_act_r   <= duty_act_next_s;
            duty_pend_r  <= duty_pend_next_s;
            pend_full_r  <= pend_full_next_s;
            pwm_out_r    <= (contador_next_s < duty_act_next_s);
            period_end_r <= boundary_s;
        end
    end

`ifdef PWM_UNDERRUN_EN
    // Underrun flag register.
    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_next_s;
        end
    end

    assign underrun = underrun_r;
`endif

    assign ref_bus.ref_ready = ~pend_full_r;
    assign contador          = contador_r;
    assign pwm_out           = pwm_out_r;
    assign period_end        = period_end_r;

endmodule

// File: tb/tb_pwm_modulador.sv
// Self-checking bench for pwm_modulador (PRESC=1 and PRESC=4 instances) against
// a period/queue-based reference model.
module tb_pwm_modulador;
    logic       clk;
    logic       reset_central;
    logic [4:0] contador1, contador4;
    logic       pwm1, pwm4, pe1, pe4;
`ifdef PWM_UNDERRUN_EN
    logic       und1, und4;
`endif
    int n_cmp;
    int n_bad;

    pwm_modulador_if bus1 ();
    pwm_modulador_if bus4 ();

    pwm_modulador #(.PRESC(1)) dut1 (
        .clk           (clk),
        .reset_central (reset_central),
        .ref_bus       (bus1),
        .contador      (contador1),
        .pwm_out       (pwm1),
        .period_end    (pe1)
`ifdef PWM_UNDERRUN_EN
        ,
        .underrun      (und1)
`endif
    );

    pwm_modulador #(.PRESC(4)) dut4 (
        .clk           (clk),
        .reset_central (reset_central),
        .ref_bus       (bus4),
        .contador      (contador4),
        .pwm_out       (pwm4),
        .period_end    (pe4)
`ifdef PWM_UNDERRUN_EN
        ,
        .underrun      (und4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: t = clk edges since reset, queues hold the pending sample.
    int t1, t4, act1, act4;
    int q1[$];
    int q4[$];
    bit m_und1, m_und4;

    always @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            t1 = 0; act1 = 0; m_und1 = 1'b0; q1.delete();
            t4 = 0; act4 = 0; m_und4 = 1'b0; q4.delete();
        end else begin : model_step
            bit acc1, acc4;
            acc1 = bus1.ref_valid && (q1.size() == 0);
            acc4 = bus4.ref_valid && (q4.size() == 0);
            if (((t1 + 1) % 32) == 0) begin
                if (q1.size() > 0) act1 = q1.pop_front(); else m_und1 = 1'b1;
            end
            if (((t4 + 1) % 128) == 0) begin
                if (q4.size() > 0) act4 = q4.pop_front(); else m_und4 = 1'b1;
            end
            if (acc1) q1.push_back(int'(bus1.ref_data));
            if (acc4) q4.push_back(int'(bus4.ref_data));
            t1++;
            t4++;
        end
    end

    // Expected {contador, pwm_out, period_end, ref_ready}
    function automatic logic [7:0] model_out(int t, int p, int act, int qs);
        int c;
        c = (t / p) % 32;
        return {c[4:0], (c < act), ((t > 0) && ((t % (32 * p)) == 0)), (qs == 0)};
    endfunction

    function automatic logic [7:0] obs1();
        return {contador1, pwm1, pe1, bus1.ref_ready};
    endfunction

    function automatic logic [7:0] obs4();
        return {contador4, pwm4, pe4, bus4.ref_ready};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_central = 1'b1;
        bus1.ref_valid = 1'b0;
        bus4.ref_valid = 1'b0;
        @(negedge clk);
        reset_central = 1'b0;
    endtask

    task automatic wait_pe(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel == 1) ? pe1 : pe4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk);
        reset_central = 1'b1;
        #1;
        n_cmp++;
        if ({obs1(), obs4()} !== 16'h0101) begin
            n_bad++; $display("FAIL reset_state got %h exp 0101", {obs1(), obs4()});
        end
        @(negedge clk);
        reset_central = 1'b0;
        bus1.ref_data = 5'd25; bus1.ref_valid = 1'b1;
        @(negedge clk);
        bus1.ref_valid = 1'b0;
        wait_pe(1, 80, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL reset_wait_pe got 0 exp 1"); end
        repeat (17) @(negedge clk);
        n_cmp++;
        if ({contador1, pwm1} !== {5'd17, 1'b1}) begin
            n_bad++; $display("FAIL reset_pre got %0d/%b exp 17/1", contador1, pwm1);
        end
        #2;
        reset_central = 1'b1;
        #1;
        n_cmp++;
        if (obs1() !== 8'h01) begin
            n_bad++; $display("FAIL reset_mid got %h exp 01", obs1());
        end
`ifdef PWM_UNDERRUN_EN
        n_cmp++;
        if (und1 !== 1'b0) begin n_bad++; $display("FAIL reset_und got %b exp 0", und1); end
`endif
        @(negedge clk);
        reset_central = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs1() !== 8'h09) begin
            n_bad++; $display("FAIL reset_restart got %h exp 09", obs1());
        end
    endtask

    task automatic test_duty_load();
        bit ok;
        int hi, pes;
        do_reset();
        bus1.ref_data = 5'd6; bus1.ref_valid = 1'b1;
        @(negedge clk);
        bus1.ref_valid = 1'b0;
        wait_pe(1, 80, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL load_wait_pe got 0 exp 1"); end
        hi = 0; pes = 0;
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (obs1() !== model_out(t1, 1, act1, q1.size())) begin
                n_bad++; $display("FAIL load_cycle got %h exp %h", obs1(), model_out(t1, 1, act1, q1.size()));
            end
            hi += int'(pwm1); pes += int'(pe1);
            @(negedge clk);
        end
        n_cmp++;
        if ({hi, pes, 1'b0 + pe1} !== {32'd6, 32'd1, 1'b1}) begin
            n_bad++; $display("FAIL load_counts got hi=%0d pe=%0d next_pe=%b exp 6 1 1", hi, pes, pe1);
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int hi0, hi31;
        logic at31;
        do_reset();
        bus1.ref_data = 5'd0; bus1.ref_valid = 1'b1;
        @(negedge clk);
        bus1.ref_valid = 1'b0;
        wait_pe(1, 80, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ext_wait_pe got 0 exp 1"); end
        hi0 = 0;
        for (int i = 0; i < 32; i++) begin
            hi0 += int'(pwm1);
            if (i == 3) begin bus1.ref_data = 5'd31; bus1.ref_valid = 1'b1; end
            if (i == 4) bus1.ref_valid = 1'b0;
            @(negedge clk);
        end
        hi31 = 0; at31 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            hi31 += int'(pwm1);
            if (contador1 == 5'd31) at31 = pwm1;
            @(negedge clk);
        end
        n_cmp++;
        if ({hi0, hi31, 1'b0 + at31} !== {32'd0, 32'd31, 1'b0}) begin
            n_bad++; $display("FAIL extremes got d0=%0d d31=%0d at31=%b exp 0 31 0", hi0, hi31, at31);
        end
    endtask

    task automatic test_backpressure();
        int stall, hi10, hi20;
        bit seen;
        do_reset();
        bus1.ref_data = 5'd10; bus1.ref_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus1.ref_ready !== 1'b0) begin n_bad++; $display("FAIL bp_first_accept got %b exp 0", bus1.ref_ready); end
        bus1.ref_data = 5'd20;
        stall = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            stall++;
            if (bus1.ref_ready) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if ({seen, pe1, stall} !== {1'b1, 1'b1, 32'd31}) begin
            n_bad++; $display("FAIL bp_release got seen=%b pe=%b stall=%0d exp 1 1 31", seen, pe1, stall);
        end
        hi10 = int'(pwm1);
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_cmp++;
                if (bus1.ref_ready !== 1'b0) begin n_bad++; $display("FAIL bp_second_accept got %b exp 0", bus1.ref_ready); end
                bus1.ref_valid = 1'b0;
            end
            hi10 += int'(pwm1);
        end
        hi20 = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            hi20 += int'(pwm1);
        end
        n_cmp++;
        if ({hi10, hi20} !== {32'd10, 32'd20}) begin
            n_bad++; $display("FAIL bp_duties got %0d,%0d exp 10,20", hi10, hi20);
        end
    endtask

    task automatic test_underrun();
        bit ok;
        int hi1, hi2, hi3;
        do_reset();
        bus1.ref_data = 5'd12; bus1.ref_valid = 1'b1;
        @(negedge clk);
        bus1.ref_valid = 1'b0;
        wait_pe(1, 80, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL und_wait_pe got 0 exp 1"); end
        hi1 = 0; hi2 = 0; hi3 = 0;
        for (int i = 0; i < 96; i++) begin
`ifdef PWM_UNDERRUN_EN
            if (i == 0 || i == 31 || i == 32 || i == 64) begin
                n_cmp++;
                if (und1 !== (i >= 32)) begin
                    n_bad++; $display("FAIL und_flag at %0d got %b exp %b", i, und1, (i >= 32));
                end
            end
`endif
            if (i < 32) hi1 += int'(pwm1);
            else if (i < 64) hi2 += int'(pwm1);
            else hi3 += int'(pwm1);
            if (i == 37) begin bus1.ref_data = 5'd5; bus1.ref_valid = 1'b1; end
            if (i == 38) bus1.ref_valid = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if ({hi1, hi2, hi3} !== {32'd12, 32'd12, 32'd5}) begin
            n_bad++; $display("FAIL und_duties got %0d,%0d,%0d exp 12,12,5", hi1, hi2, hi3);
        end
    endtask

    task automatic test_prescaler();
        bit ok;
        int hi, pes;
        do_reset();
        bus4.ref_data = 5'd8; bus4.ref_valid = 1'b1;
        @(negedge clk);
        bus4.ref_valid = 1'b0;
        wait_pe(4, 300, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL presc_wait_pe got 0 exp 1"); end
        hi = 0; pes = 0;
        for (int i = 0; i < 128; i++) begin
            n_cmp++;
            if (contador4 !== 5'(i / 4)) begin
                n_bad++; $display("FAIL presc_step got %0d exp %0d", contador4, i / 4);
            end
            hi += int'(pwm4); pes += int'(pe4);
            @(negedge clk);
        end
        n_cmp++;
        if ({hi, pes, 1'b0 + pe4} !== {32'd32, 32'd1, 1'b1}) begin
            n_bad++; $display("FAIL presc_counts got hi=%0d pe=%0d next_pe=%b exp 32 1 1", hi, pes, pe4);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({obs1(), obs4()} !== {model_out(t1, 1, act1, q1.size()), model_out(t4, 4, act4, q4.size())}) begin
                n_bad++;
                $display("FAIL rand_cycle %0d got %h/%h exp %h/%h", i, obs1(), obs4(),
                         model_out(t1, 1, act1, q1.size()), model_out(t4, 4, act4, q4.size()));
            end
`ifdef PWM_UNDERRUN_EN
            n_cmp++;
            if ({und1, und4} !== {m_und1, m_und4}) begin
                n_bad++; $display("FAIL rand_und got %b%b exp %b%b", und1, und4, m_und1, m_und4);
            end
`endif
            bus1.ref_valid = ($urandom_range(0, 99) < 8);
            bus1.ref_data  = 5'($urandom_range(0, 31));
            bus4.ref_valid = ($urandom_range(0, 99) < 3);
            bus4.ref_data  = 5'($urandom_range(0, 31));
        end
        bus1.ref_valid = 1'b0;
        bus4.ref_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_central  = 1'b1;
        bus1.ref_valid = 1'b0;
        bus1.ref_data  = 5'd0;
        bus4.ref_valid = 1'b0;
        bus4.ref_data  = 5'd0;
        test_reset();
        test_duty_load();
        test_extremes();
        test_backpressure();
        test_underrun();
        test_prescaler();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
